// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions for the hazard/interlock controller.
//   - default widths and MDU latency
//   - MDU tracker state encoding
//   - zero-register constant (r0 never creates a dependency)
//   - pipeline control bundle and its canned values
package hazard_unit_pkg;

  localparam int unsigned DEF_REG_ADDR_WIDTH = 5;
  localparam int unsigned DEF_MDU_LATENCY    = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

  localparam logic [DEF_REG_ADDR_WIDTH-1:0] ZERO_REG = '0;

  // Enables/flushes for PC, IF/ID and ID/EX, in that order
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
  } pipe_ctrl_t;

  // Held in reset: nothing advances, both pipeline registers hold bubbles
  localparam pipe_ctrl_t CTRL_RESET  = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1,
                                         id_ex_en: 1'b0, id_ex_flush: 1'b1};
  // Redirect: fetch the target, squash IF/ID and ID/EX
  localparam pipe_ctrl_t CTRL_REDIR  = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1,
                                         id_ex_en: 1'b1, id_ex_flush: 1'b1};
  // Interlock: hold IF and ID, push a bubble into EX
  localparam pipe_ctrl_t CTRL_STALL  = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                         id_ex_en: 1'b1, id_ex_flush: 1'b1};
  // Free-running pipeline
  localparam pipe_ctrl_t CTRL_RUN    = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
                                         id_ex_en: 1'b1, id_ex_flush: 1'b0};

endpackage : hazard_unit_pkg

// File: rtl/hazard_unit_mdu_tracker.sv
// Tracks the multi-cycle multiply/divide unit.
// A start in IDLE enters BUSY for exactly MDU_LATENCY cycles.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   start       EX instruction starts an MDU op this cycle
//   busy        tracker is in BUSY
//   done        last BUSY cycle (leaves BUSY on the next edge)
module hazard_unit_mdu_tracker
  import hazard_unit_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = DEF_MDU_LATENCY,
  parameter int unsigned CNT_WIDTH   = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done
);

  mdu_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // State and countdown registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; a start while BUSY is ignored (no reload)
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          cnt_d   = CNT_WIDTH'(MDU_LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q == BUSY);
  assign done = busy && (cnt_q == '0);

  // A second start while the MDU is still working is a decode/issue bug
  assert property (@(posedge clk) disable iff (!rst_n) !(start && busy))
    else $error("mdu_tracker: start while BUSY ignored");

endmodule : hazard_unit_mdu_tracker

// File: rtl/hazard_unit.sv
// Pipeline interlock controller for the 5-stage core.
// Drives PC / IF/ID / ID/EX enables and flushes from load-use hazards,
// MDU busy interlocks and taken-branch redirects; counts stall cycles.
// Ports:
//   clk, rst_n            clock / async active-low reset
//   id_rs, id_rt          source registers of the ID instruction
//   id_use_rs, id_use_rt  ID instruction actually reads rs / rt
//   id_mdu_op             ID instruction needs the MDU (hi/lo or mult/div)
//   ex_mem_read, ex_rd    EX instruction is a load, and its destination
//   ex_mdu_start          EX instruction starts a mult/div
//   branch_taken          EX resolved a taken branch/jump
//   perf_clr              synchronous clear of stall_cycles
//   pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush  pipeline control (same cycle)
//   mdu_busy              MDU tracker in BUSY
//   stall_cycles          saturating stall-cycle counter
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int unsigned MDU_LATENCY    = DEF_MDU_LATENCY,
  parameter int unsigned CNT_WIDTH      = 3,
  parameter int unsigned PERF_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic                      id_use_rs,
  input  logic                      id_use_rt,
  input  logic                      id_mdu_op,
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_mdu_start,
  input  logic                      branch_taken,
  input  logic                      perf_clr,
  output logic                      pc_en,
  output logic                      if_id_en,
  output logic                      if_id_flush,
  output logic                      id_ex_en,
  output logic                      id_ex_flush,
  output logic                      mdu_busy,
  output logic [PERF_WIDTH-1:0]     stall_cycles
);

  logic       mdu_done;
  logic       load_use;
  logic       mdu_stall;
  logic       stall;
  logic       count_stall;
  pipe_ctrl_t ctrl;

  // MDU busy tracking; unaffected by branch_taken since the EX op is committed
  hazard_unit_mdu_tracker #(
    .MDU_LATENCY (MDU_LATENCY),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_mdu_tracker (
    .clk   (clk),
    .rst_n (rst_n),
    .start (ex_mdu_start),
    .busy  (mdu_busy),
    .done  (mdu_done)
  );

  // Load-use: EX load writes a register the ID instruction reads; r0 is exempt
  assign load_use = ex_mem_read
                  && (ex_rd != REG_ADDR_WIDTH'(ZERO_REG))
                  && ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));

  assign mdu_stall   = id_mdu_op && mdu_busy;
  assign stall       = load_use || mdu_stall;
  // A stall coinciding with a redirect is squashed, so it is not counted
  assign count_stall = stall && !branch_taken;

  // Control priority: reset, redirect, stall, run
  always_comb begin
    ctrl = CTRL_RUN;
    if (!rst_n) begin
      ctrl = CTRL_RESET;
    end else if (branch_taken) begin
      ctrl = CTRL_REDIR;
    end else if (stall) begin
      ctrl = CTRL_STALL;
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign if_id_en    = ctrl.if_id_en;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_en    = ctrl.id_ex_en;
  assign id_ex_flush = ctrl.id_ex_flush;

  // Saturating stall counter; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (perf_clr) begin
      stall_cycles <= '0;
    end else if (count_stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + PERF_WIDTH'(1);
    end
  end

  // The last BUSY cycle must always be followed by IDLE
  assert property (@(posedge clk) disable iff (!rst_n) mdu_done |=> !mdu_busy)
    else $error("hazard_unit: MDU stayed busy after done");

endmodule : hazard_unit
